// File: rtl/sd_spi_pkg.sv
// Shared constants and state encoding for the SPI-mode SD card responder.
package sd_spi_pkg;

    localparam logic [5:0] CMD0  = 6'd0;
    localparam logic [5:0] CMD8  = 6'd8;
    localparam logic [5:0] CMD17 = 6'd17;
    localparam logic [5:0] CMD24 = 6'd24;
    localparam logic [5:0] CMD41 = 6'd41;
    localparam logic [5:0] CMD55 = 6'd55;
    localparam logic [5:0] CMD58 = 6'd58;

    localparam logic [7:0]  TOK_START    = 8'hFE;
    localparam logic [7:0]  TOK_DRESP_OK = 8'h05;
    localparam int          R1_IDLE      = 0;
    localparam int          R1_ILLEGAL   = 2;
    localparam logic [31:0] OCR          = 32'hC0FF_8000;

    typedef enum logic [3:0] {
        CMD_RX, RESP,
        RD_GAP, RD_TOKEN, RD_DATA, RD_CRC,
        WR_TOKEN, WR_DATA, WR_CRC, WR_DRESP, WR_BUSY
    } state_t;

    function automatic logic [7:0] r1(input logic idle, input logic illegal);
        logic [7:0] v;
        v             = 8'h00;
        v[R1_IDLE]    = idle;
        v[R1_ILLEGAL] = illegal;
        return v;
    endfunction

endpackage

// File: rtl/sd_spi_byte_phy.sv
// Oversampled SPI byte PHY: syncs sd_clk/cs/mosi, shifts rx on rise, tx on fall,
// and reloads the tx shifter on every 8th rise so card bytes line up with host bytes.
module sd_spi_byte_phy (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sd_clk,
    input  logic       i_sd_cs,
    input  logic       i_sd_mosi,
    output logic       o_sd_miso,
    output logic       o_cs_active,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_valid,
    output logic       o_tx_load,
    input  logic [7:0] i_tx_byte
);
    logic [1:0] r_clk_s, r_cs_s, r_mosi_s;
    logic       r_clk_d;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_rx_sr, r_tx_sr;
    logic       w_rise, w_fall;

    assign w_rise      = r_clk_s[1] & ~r_clk_d;
    assign w_fall      = ~r_clk_s[1] & r_clk_d;
    assign o_cs_active = ~r_cs_s[1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clk_s    <= 2'b00;
            r_cs_s     <= 2'b11;
            r_mosi_s   <= 2'b11;
            r_clk_d    <= 1'b0;
            r_bit_cnt  <= 3'd0;
            r_rx_sr    <= 8'h00;
            r_tx_sr    <= 8'hFF;
            o_sd_miso  <= 1'b1;
            o_rx_byte  <= 8'h00;
            o_rx_valid <= 1'b0;
            o_tx_load  <= 1'b0;
        end else begin
            r_clk_s    <= {r_clk_s[0], i_sd_clk};
            r_cs_s     <= {r_cs_s[0], i_sd_cs};
            r_mosi_s   <= {r_mosi_s[0], i_sd_mosi};
            r_clk_d    <= r_clk_s[1];
            o_rx_valid <= 1'b0;
            o_tx_load  <= 1'b0;
            if (r_cs_s[1]) begin
                r_bit_cnt <= 3'd0;
                r_tx_sr   <= 8'hFF;
                o_sd_miso <= 1'b1;
            end else if (w_rise) begin
                r_rx_sr   <= {r_rx_sr[6:0], r_mosi_s[1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    o_rx_byte  <= {r_rx_sr[6:0], r_mosi_s[1]};
                    o_rx_valid <= 1'b1;
                    o_tx_load  <= 1'b1;
                    r_tx_sr    <= i_tx_byte;
                end
            end else if (w_fall) begin
                o_sd_miso <= r_tx_sr[7];
                r_tx_sr   <= {r_tx_sr[6:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/sd_spi_card_model.sv
// SPI-mode SD card responder: command decode, R1/R3/R7 replies and
// single-block read/write sequencing against a byte-wide memory port.
module sd_spi_card_model #(
    parameter int INIT_RETRIES = 2,
    parameter int NAC_BYTES    = 1,
    parameter int BUSY_BYTES   = 4
) (
    input  logic        i_clk_ref,
    input  logic        i_rst,
    input  logic        i_sd_clk,
    input  logic        i_sd_cs,
    input  logic        i_sd_mosi,
    output logic        o_sd_miso,
    output logic [31:0] o_mem_sec_addr,
    output logic [8:0]  o_mem_byte_idx,
    output logic        o_mem_rd_en,
    input  logic [7:0]  i_mem_rd_data,
    output logic        o_mem_wr_en,
    output logic [7:0]  o_mem_wr_data,
    output logic        o_card_ready
);
    import sd_spi_pkg::*;

    logic            w_cs_active, w_rx_valid, w_tx_load;
    logic [7:0]      w_rx_byte;
    state_t          r_state, r_after, w_after;
    logic [7:0]      r_tx_byte, r_cnt, r_acmd41_cnt, w_r1;
    logic [2:0]      r_cmd_cnt, r_resp_left, w_resp_n;
    logic [5:0]      r_cmd_idx;
    logic [31:0]     r_arg;
    logic [3:0][7:0] r_resp, w_resp;
    logic            r_in_idle, r_app_cmd, r_rd_cap, w_illegal;

    sd_spi_byte_phy u_phy (
        .i_clk       (i_clk_ref),
        .i_rst       (i_rst),
        .i_sd_clk    (i_sd_clk),
        .i_sd_cs     (i_sd_cs),
        .i_sd_mosi   (i_sd_mosi),
        .o_sd_miso   (o_sd_miso),
        .o_cs_active (w_cs_active),
        .o_rx_byte   (w_rx_byte),
        .o_rx_valid  (w_rx_valid),
        .o_tx_load   (w_tx_load),
        .i_tx_byte   (r_tx_byte)
    );

    assign o_card_ready = ~r_in_idle;

    // Response for the frame in r_cmd_idx/r_arg; r_resp[3] goes out right after R1.
    always_comb begin
        w_illegal = 1'b0;
        w_after   = CMD_RX;
        w_resp    = {4{8'hFF}};
        w_resp_n  = 3'd0;
        w_r1      = r1(r_in_idle, 1'b0);
        case (r_cmd_idx)
            CMD0, CMD55: ;
            CMD8: begin
                w_resp   = {8'h00, 8'h00, {4'h0, r_arg[11:8]}, r_arg[7:0]};
                w_resp_n = 3'd4;
            end
            CMD41: begin
                if (!r_app_cmd) w_illegal = 1'b1;
                else w_r1 = (r_acmd41_cnt < 8'(INIT_RETRIES)) ? 8'h01 : 8'h00;
            end
            CMD58: begin
                w_resp   = OCR;
                w_resp_n = 3'd4;
            end
            CMD17, CMD24: begin
                if (r_in_idle) w_illegal = 1'b1;
                else w_after = (r_cmd_idx == CMD17) ? RD_GAP : WR_TOKEN;
            end
            default: w_illegal = 1'b1;
        endcase
        if (w_illegal) w_r1 = r1(r_in_idle, 1'b1);
    end

    // r_tx_byte is the byte the PHY loads at the next boundary, i.e. two host bytes ahead.
    always_ff @(posedge i_clk_ref) begin
        if (i_rst) begin
            r_state        <= CMD_RX;
            r_after        <= CMD_RX;
            r_tx_byte      <= 8'hFF;
            r_cnt          <= 8'd0;
            r_acmd41_cnt   <= 8'd0;
            r_cmd_cnt      <= 3'd0;
            r_resp_left    <= 3'd0;
            r_cmd_idx      <= 6'd0;
            r_arg          <= 32'd0;
            r_resp         <= {4{8'hFF}};
            r_in_idle      <= 1'b1;
            r_app_cmd      <= 1'b0;
            r_rd_cap       <= 1'b0;
            o_mem_sec_addr <= 32'd0;
            o_mem_byte_idx <= 9'd0;
            o_mem_rd_en    <= 1'b0;
            o_mem_wr_en    <= 1'b0;
            o_mem_wr_data  <= 8'h00;
        end else if (!w_cs_active) begin
            r_state        <= CMD_RX;
            r_tx_byte      <= 8'hFF;
            r_cmd_cnt      <= 3'd0;
            r_rd_cap       <= 1'b0;
            o_mem_byte_idx <= 9'd0;
            o_mem_rd_en    <= 1'b0;
            o_mem_wr_en    <= 1'b0;
        end else begin
            o_mem_rd_en <= 1'b0;
            o_mem_wr_en <= 1'b0;
            r_rd_cap    <= o_mem_rd_en;
            if (r_rd_cap) r_tx_byte <= i_mem_rd_data;
            if (o_mem_wr_en) o_mem_byte_idx <= o_mem_byte_idx + 9'd1;
            if (w_tx_load) begin
                case (r_state)
                    CMD_RX: if (w_rx_valid) begin
                        if (r_cmd_cnt == 3'd0) begin
                            if (w_rx_byte[7:6] == 2'b01) begin
                                r_cmd_idx <= w_rx_byte[5:0];
                                r_cmd_cnt <= 3'd1;
                            end
                        end else if (r_cmd_cnt != 3'd5) begin
                            r_arg     <= {r_arg[23:0], w_rx_byte};
                            r_cmd_cnt <= r_cmd_cnt + 3'd1;
                        end else begin
                            r_cmd_cnt   <= 3'd0;
                            r_tx_byte   <= w_r1;
                            r_resp      <= w_resp;
                            r_resp_left <= w_resp_n;
                            r_after     <= w_after;
                            r_state     <= RESP;
                            r_app_cmd   <= (r_cmd_idx == CMD55);
                            case (r_cmd_idx)
                                CMD0: r_in_idle <= 1'b1;
                                CMD41: if (r_app_cmd) begin
                                    if (r_acmd41_cnt < 8'(INIT_RETRIES)) r_acmd41_cnt <= r_acmd41_cnt + 8'd1;
                                    else r_in_idle <= 1'b0;
                                end
                                CMD17, CMD24: if (!r_in_idle) o_mem_sec_addr <= r_arg;
                                default: ;
                            endcase
                        end
                    end
                    RESP: if (r_resp_left != 3'd0) begin
                        r_tx_byte   <= r_resp[3];
                        r_resp      <= {r_resp[2:0], 8'hFF};
                        r_resp_left <= r_resp_left - 3'd1;
                    end else begin
                        r_state   <= r_after;
                        r_cnt     <= 8'd0;
                        r_tx_byte <= 8'hFF;
                    end
                    RD_GAP: if (r_cnt == 8'(NAC_BYTES - 1)) begin
                        r_tx_byte <= TOK_START;
                        r_state   <= RD_TOKEN;
                    end else r_cnt <= r_cnt + 8'd1;
                    RD_TOKEN: begin
                        o_mem_rd_en <= 1'b1;
                        r_state     <= RD_DATA;
                    end
                    RD_DATA: if (o_mem_byte_idx == 9'd511) begin
                        o_mem_byte_idx <= 9'd0;
                        r_tx_byte      <= 8'hFF;
                        r_cnt          <= 8'd0;
                        r_state        <= RD_CRC;
                    end else begin
                        o_mem_byte_idx <= o_mem_byte_idx + 9'd1;
                        o_mem_rd_en    <= 1'b1;
                    end
                    RD_CRC: if (r_cnt == 8'd1) r_state <= CMD_RX;
                            else r_cnt <= r_cnt + 8'd1;
                    WR_TOKEN: if (w_rx_byte == TOK_START) r_state <= WR_DATA;
                    WR_DATA: begin
                        o_mem_wr_en   <= 1'b1;
                        o_mem_wr_data <= w_rx_byte;
                        if (o_mem_byte_idx == 9'd511) begin
                            r_cnt   <= 8'd0;
                            r_state <= WR_CRC;
                        end
                    end
                    WR_CRC: if (r_cnt == 8'd1) begin
                        r_tx_byte <= TOK_DRESP_OK;
                        r_state   <= WR_DRESP;
                    end else r_cnt <= r_cnt + 8'd1;
                    WR_DRESP: begin
                        r_tx_byte <= 8'h00;
                        r_cnt     <= 8'd0;
                        r_state   <= WR_BUSY;
                    end
                    WR_BUSY: if (r_cnt == 8'(BUSY_BYTES - 1)) begin
                        r_tx_byte <= 8'hFF;
                        r_state   <= CMD_RX;
                    end else r_cnt <= r_cnt + 8'd1;
                    default: r_state <= CMD_RX;
                endcase
            end
        end
    end

endmodule

// File: doc/sd_spi_card_model.md
Name: sd_spi_card_model

Overview:
- SPI-mode SD card responder: the card side of the link driven by our SD host controller (init, single-block read, single-block write).
- Oversamples sd_clk, sd_cs and sd_mosi in the clk_ref domain, decodes 48-bit command frames and returns R1/R3/R7 responses.
- Serves CMD17 reads and CMD24 writes through a byte-wide external memory port.
- Used as an in-fabric loopback target and as the DUT partner for host-controller regression.

Parameters:
- INIT_RETRIES, 2: number of ACMD41 attempts that return 0x01 before returning 0x00.
- NAC_BYTES, 1: 0xFF bytes between the CMD17 R1 and the 0xFE token.
- BUSY_BYTES, 4: 0x00 busy bytes after the write data response.

Ports:
- clk_ref  in  1: sole clock; must be at least 4x the sd_clk frequency.
- rst  in  1: synchronous, active-high reset.
- sd_clk  in  1: SPI clock from the host; asynchronous, synchronised internally.
- sd_cs  in  1: chip select, active low.
- sd_mosi  in  1: host-to-card data.
- sd_miso  out  1: card-to-host data.
- mem_sec_addr  out  32: sector address latched from the CMD17/CMD24 argument.
- mem_byte_idx  out  9: byte offset within the sector, 0..511.
- mem_rd_en  out  1: read strobe; mem_rd_data must be valid exactly 1 clk_ref later.
- mem_rd_data  in  8: read data.
- mem_wr_en  out  1: 1-cycle write strobe.
- mem_wr_data  out  8: write data.
- card_ready  out  1: high when the card has left idle (in_idle = 0).

Behaviour:
- Reset values: sd_miso = 1; mem_* outputs = 0; card_ready = 0. Internally in_idle = 1, app_cmd = 0, acmd41_cnt = 0, FSM = CMD_RX.
- Input sync and sampling:
  - sd_clk, sd_cs and sd_mosi each pass through a 2-flop synchroniser; sd_clk edges are detected on the synchronised value.
  - mosi is sampled on sd_clk rise.
  - sd_miso <= tx_sr[7] and tx_sr shifts left on sd_clk fall.
  - At every 8th rise the next tx byte is loaded, so MSB-first bytes are aligned to the host's bytes.
  - Default tx byte is 0xFF.
- sd_cs high: bit counter cleared, FSM forced to CMD_RX, sd_miso = 1, no mem strobes. Any in-flight read or write is abandoned; a partial write keeps the bytes already written.
- CMD_RX:
  - Ignore bytes until one matches 01xxxxxx.
  - Collect 6 bytes (index, 32-bit argument MSB first, CRC); CRC is not checked.
  - After the 6th byte, emit NCR = 1 byte of 0xFF, then the response.
- Responses (R1 bit0 = in_idle):
  - CMD0: in_idle <= 1; R1.
  - CMD8: R7 = R1, 0x00, 0x00, {4'h0, arg[11:8]}, arg[7:0].
  - CMD55: app_cmd <= 1; R1.
  - ACMD41 (CMD41 with app_cmd = 1): if acmd41_cnt < INIT_RETRIES, increment acmd41_cnt and reply 0x01; else in_idle <= 0 and reply 0x00.
  - CMD58: R3 = R1, 0xC0, 0xFF, 0x80, 0x00 (CCS = 1).
  - CMD17/CMD24: with in_idle = 1 reply 0x05 and perform no data phase; otherwise latch arg into mem_sec_addr, reply 0x00 and enter the data phase.
  - Any other index: R1 | 0x04.
  - app_cmd clears after any command other than CMD55.
- Read path: RD_GAP (NAC_BYTES x 0xFF) -> RD_TOKEN (0xFE) -> RD_DATA -> RD_CRC -> CMD_RX.
  - RD_DATA: for idx 0..511, mem_rd_en pulses 2 clk_ref after the byte-load boundary of the previous byte; data is captured into the tx holding register. Memory reads therefore have 1-cycle latency and always complete before the next load.
  - RD_CRC: 0xFF, 0xFF.
- Write path: WR_TOKEN (wait for rx byte 0xFE; other bytes ignored) -> WR_DATA -> WR_CRC -> WR_DRESP -> WR_BUSY -> CMD_RX.
  - WR_DATA: each received byte produces mem_wr_en for 1 cycle with mem_byte_idx = 0..511.
  - WR_CRC: 2 bytes discarded.
  - WR_DRESP: tx 0x05.
  - WR_BUSY: BUSY_BYTES x 0x00, then 0xFF.
- mem_byte_idx is 9 bits and returns to 0 after 511, when leaving the data state; no carry into mem_sec_addr.
- A command start byte arriving while a response is being sent is ignored (single outstanding command).

Decomposition:
- Package sd_spi_pkg holds:
  - Command indices CMD0/8/17/24/41/55/58.
  - Tokens 0xFE, 0x05.
  - R1 bit positions (IDLE = 0, ILLEGAL = 2).
  - OCR constant.
  - FSM state enum.
- Sub-module sd_spi_byte_phy owns the synchronisers, edge detect, rx/tx shift registers and bit counter. It exposes rx_byte, rx_valid (1-cycle pulse), tx_load (pulse on byte boundary) and tx_byte in, with cs-high clearing.
- The top module holds the command FSM and the memory sequencing.

Test Plan:
- After reset, CMD0 (40 00 00 00 00 95) -> sd_miso bytes FF, 01; card_ready = 0.
- CMD8 arg 0x000001AA -> FF, 01, 00, 00, 01, AA.
- CMD55 + ACMD41 repeated 3x with INIT_RETRIES = 2 -> ACMD41 R1 sequence 01, 01, 00; card_ready rises after the third; CMD58 -> 00, C0, FF, 80, 00.
- CMD17 arg 5, memory holding byte = idx[7:0] -> 00, FF, FE, bytes 00..FF twice, FF, FF; mem_sec_addr = 5; 512 mem_rd_en pulses.
- CMD24 arg 9 with token FE plus 512 bytes of 0xA5 -> 512 mem_wr_en pulses with data A5 and idx 0..511; response 05, then 00 x4, then FF.
- sd_cs raised after the 100th CMD17 data byte -> sd_miso = 1, no further mem_rd_en; next CMD0 -> FF, 00.
- Unknown CMD13 after init -> FF, 04.
- CMD17 sent before init completes -> FF, 05, with no token.
